vec_mem_xfer_ctrl: RTL and testbench

- Vector load/store transfer controller.
- Sits directly upstream of the memory address sequencer and drives its read_enable, write_enable and input_address.
- On a start request it runs one fixed-length burst of BURST_LEN elements:
  - store: serializes a packed vector register onto the memory write-data bus, one element per beat.
  - load: deserializes per-beat memory read data into a packed vector, then signals completion to the vector pipeline.

---
 rtl/vec_mem_pkg.sv | 33 +++
 rtl/vec_mem_xfer_ctrl_vec_rd_capture.sv | 52 +++++
 rtl/vec_mem_xfer_ctrl.sv | 125 ++++++++++++
 tb/tb_vec_mem_xfer_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared types, constants and helpers for the vector
// load/store transfer controller (vec_mem_xfer_ctrl, vec_rd_capture).
//   xfer_state_t : transfer FSM state encoding
//   VEC_BURST_LEN, MEM_ADDR_W, ELEM_W : default geometry
//   elem_sel()   : pick element idx out of a packed vector
package vec_mem_pkg;

  localparam int VEC_BURST_LEN = 18;
  localparam int MEM_ADDR_W    = 19;
  localparam int ELEM_W        = 8;
  localparam int VEC_CNT_W     = $clog2(VEC_BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  // Mux-style select keeps the index compare within the counter width.
  function automatic logic [ELEM_W-1:0] elem_sel(
    input logic [VEC_BURST_LEN*ELEM_W-1:0] vec,
    input logic [VEC_CNT_W-1:0]            idx
  );
    logic [ELEM_W-1:0] r;
    r = '0;
    for (int i = 0; i < VEC_BURST_LEN; i++) begin
      if (idx == VEC_CNT_W'(i)) r = vec[i*ELEM_W +: ELEM_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/vec_mem_xfer_ctrl_vec_rd_capture.sv
// vec_rd_capture: load-side capture path. Delays the read-beat strobe by
// RD_LAT cycles to line it up with mem_rdata, then writes each captured
// word into the next element of rdata_vec. Updates on the falling edge.
//   clk, rst   : clock (falling-edge active), async active-high reset
//   rd_beat    : read enable issued to memory this cycle
//   mem_rdata  : memory read data
//   rdata_vec  : packed result, element i at [i*DATA_W +: DATA_W]
module vec_rd_capture import vec_mem_pkg::*; #(
  parameter int DATA_W    = ELEM_W,
  parameter int BURST_LEN = VEC_BURST_LEN,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_beat,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [BURST_LEN*DATA_W-1:0] rdata_vec
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(BURST_LEN - 1);

  logic             cap_vld;
  logic [CNT_W-1:0] cap_ptr;

  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign cap_vld = rd_beat;
    end else begin : g_lat
      logic [RD_LAT-1:0] dly;
      always_ff @(negedge clk or posedge rst) begin
        if (rst) dly <= '0;
        else     dly <= (dly << 1) | RD_LAT'(rd_beat);
      end
      assign cap_vld = dly[RD_LAT-1];
    end
  endgenerate

  // Pointer wraps explicitly after the last element so every load starts at 0.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cap_ptr   <= '0;
      rdata_vec <= '0;
    end else if (cap_vld) begin
      cap_ptr <= (cap_ptr == CAP_LAST) ? '0 : cap_ptr + CNT_W'(1);
      for (int i = 0; i < BURST_LEN; i++) begin
        if (cap_ptr == CNT_W'(i)) rdata_vec[i*DATA_W +: DATA_W] <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/vec_mem_xfer_ctrl.sv
// vec_mem_xfer_ctrl: vector load/store burst controller feeding the memory
// address sequencer. One start runs BURST_LEN beats with the selected enable
// held high and mem_addr fixed at the captured base; the sequencer does the
// address increment. All state changes on the falling edge of clk.
//   start/is_store/base_addr/wdata_vec : request, captured in IDLE
//   busy, done                         : status (done is a 1-cycle pulse)
//   mem_read_enable/mem_write_enable   : sequencer enables
//   mem_addr, mem_wdata, mem_rdata     : memory side
//   rdata_vec                          : load result
// Optional macro VEC_XFER_BOUNDS_CHECK_EN adds output err and rejects bursts
// whose last element would run past the top of the address space.
//
// state | meaning
// IDLE  | waiting for start, mem_addr follows base_addr
// XFER  | BURST_LEN beats, enable high
// DRAIN | load only, RD_LAT cycles to capture in-flight read data
// DONE  | one-cycle done pulse, enables low
module vec_mem_xfer_ctrl import vec_mem_pkg::*; #(
  parameter int DATA_W    = ELEM_W,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int BURST_LEN = VEC_BURST_LEN,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        is_store,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [BURST_LEN*DATA_W-1:0] wdata_vec,
  output logic [BURST_LEN*DATA_W-1:0] rdata_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_read_enable,
  output logic                        mem_write_enable,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
`ifdef VEC_XFER_BOUNDS_CHECK_EN
  output logic                        err,
`endif
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  xfer_state_t                 state;
  logic [CNT_W-1:0]            beat;
  logic                        store_q;
  logic [ADDR_W-1:0]           base_q;
  logic [BURST_LEN*DATA_W-1:0] wdata_q;
  logic                        reject;

`ifdef VEC_XFER_BOUNDS_CHECK_EN
  logic [ADDR_W:0] last_addr;
  logic            err_q;

  // Carry into bit ADDR_W means the last element lies past the address space.
  assign last_addr = {1'b0, base_addr} + (ADDR_W+1)'(BURST_LEN - 1);
  assign reject    = last_addr[ADDR_W];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && start && reject;
  end
  assign err = err_q;
`else
  assign reject = 1'b0;
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          store_q <= is_store;
          base_q  <= base_addr;
          wdata_q <= wdata_vec;
          beat    <= '0;
          state   <= reject ? DONE : XFER;
        end
        XFER: if (beat == BEAT_LAST) begin
          beat  <= '0;
          state <= (!store_q && RD_LAT > 0) ? DRAIN : DONE;
        end else begin
          beat <= beat + CNT_W'(1);
        end
        DRAIN: if (beat == DRAIN_LAST) begin
          beat  <= '0;
          state <= DONE;
        end else begin
          beat <= beat + CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from state so an async reset drops the enables at once.
  assign mem_write_enable = (state == XFER) && store_q;
  assign mem_read_enable  = (state == XFER) && !store_q;
  assign busy             = (state == XFER) || (state == DRAIN);
  assign done             = (state == DONE);
  assign mem_addr         = (state == IDLE) ? base_addr : base_q;
  assign mem_wdata        = mem_write_enable ? elem_sel(wdata_q, beat) : '0;

  vec_rd_capture #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .RD_LAT    (RD_LAT)
  ) u_rd_capture (
    .clk       (clk),
    .rst       (rst),
    .rd_beat   (mem_read_enable),
    .mem_rdata (mem_rdata),
    .rdata_vec (rdata_vec)
  );

endmodule

// File: tb/tb_vec_mem_xfer_ctrl.sv
// Directed bench for vec_mem_xfer_ctrl (default parameters, RD_LAT = 1).
// Outputs are sampled 1 ns after the rising edge, midway between the
// falling edges on which the design updates. Define VEC_XFER_BOUNDS_CHECK_EN
// to include the err port and the address bounds steps.
module tb_vec_mem_xfer_ctrl;

  localparam int DW = 8;
  localparam int AW = 19;
  localparam int BL = 18;
  localparam int VW = BL * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          is_store;
  logic [AW-1:0] base_addr;
  logic [VW-1:0] wdata_vec;
  logic [VW-1:0] rdata_vec;
  logic          busy;
  logic          done;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef VEC_XFER_BOUNDS_CHECK_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vec_mem_xfer_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .is_store         (is_store),
    .base_addr        (base_addr),
    .wdata_vec        (wdata_vec),
    .rdata_vec        (rdata_vec),
    .busy             (busy),
    .done             (done),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
`ifdef VEC_XFER_BOUNDS_CHECK_EN
    .err              (err),
`endif
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts enables from the current cycle on and stops on the done cycle.
  task automatic run_to_done(input int limit, output int we_n, output int re_n, output bit seen);
    we_n = 0;
    re_n = 0;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      if (mem_write_enable) we_n++;
      if (mem_read_enable)  re_n++;
      if (done) seen = 1'b1;
      else      tick();
    end
  endtask

  initial begin
    int            we_n, re_n, done_n;
    bit            seen;
    bit            addr_ok;
    logic [VW-1:0] exp_vec;

    rst       = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = '0;
    wdata_vec = '0;
    mem_rdata = '0;
    tick();
    tick();

    // reset state
    chk("rst_busy",  VW'(busy), VW'(0));
    chk("rst_done",  VW'(done), VW'(0));
    chk("rst_we",    VW'(mem_write_enable), VW'(0));
    chk("rst_re",    VW'(mem_read_enable), VW'(0));
    chk("rst_addr",  VW'(mem_addr), VW'(0));
    chk("rst_wdata", VW'(mem_wdata), VW'(0));
    chk("rst_rvec",  rdata_vec, VW'(0));
    rst = 1'b0;
    tick();

    // IDLE address pass-through
    base_addr = 19'h12345;
    #1;
    chk("idle_addr", VW'(mem_addr), VW'(19'h12345));

    // store burst, element i = i+1
    for (int i = 0; i < BL; i++) wdata_vec[i*DW +: DW] = DW'(i + 1);
    base_addr = 19'h00100;
    is_store  = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = 19'h3FFFF;
    we_n      = 0;
    done_n    = 0;
    addr_ok   = 1'b1;
    for (int k = 0; k < BL; k++) begin
      chk("st_wdata", VW'(mem_wdata), VW'(k + 1));
      if (mem_write_enable) we_n++;
      if (done) done_n++;
      if (mem_addr !== 19'h00100) addr_ok = 1'b0;
      tick();
    end
    chk("st_we_cnt",    VW'(we_n), VW'(BL));
    chk("st_addr_hold", VW'(addr_ok), VW'(1));
    chk("st_no_early_done", VW'(done_n), VW'(0));
    chk("st_done",      VW'(done), VW'(1));
    chk("st_done_we",   VW'(mem_write_enable), VW'(0));
    chk("st_done_busy", VW'(busy), VW'(0));
    chk("st_done_wd",   VW'(mem_wdata), VW'(0));
    tick();
    chk("st_done_once", VW'(done), VW'(0));

    // load burst, read data = 0xA0 + beat, one cycle after the beat
    is_store = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    re_n  = 0;
    for (int k = 0; k <= BL; k++) begin
      mem_rdata = (k >= 1) ? DW'(8'hA0 + k - 1) : DW'(8'h00);
      if (mem_read_enable) re_n++;
      if (k == BL) begin
        chk("ld_drain_busy", VW'(busy), VW'(1));
        chk("ld_drain_re",   VW'(mem_read_enable), VW'(0));
        chk("ld_drain_done", VW'(done), VW'(0));
      end
      tick();
    end
    for (int i = 0; i < BL; i++) exp_vec[i*DW +: DW] = DW'(8'hA0 + i);
    chk("ld_re_cnt", VW'(re_n), VW'(BL));
    chk("ld_done",   VW'(done), VW'(1));
    chk("ld_rvec",   rdata_vec, exp_vec);
    tick();
    chk("ld_rvec_hold", rdata_vec, exp_vec);

    // back-to-back: start held high
    is_store = 1'b1;
    start    = 1'b1;
    tick();
    we_n = 0;
    for (int k = 0; k < BL; k++) begin
      if (mem_write_enable) we_n++;
      tick();
    end
    chk("b2b_we_cnt1", VW'(we_n), VW'(BL));
    chk("b2b_done",    VW'(done), VW'(1));
    chk("b2b_done_we", VW'(mem_write_enable), VW'(0));
    tick();
    chk("b2b_idle_we",   VW'(mem_write_enable), VW'(0));
    chk("b2b_idle_busy", VW'(busy), VW'(0));
    chk("b2b_idle_done", VW'(done), VW'(0));
    tick();
    chk("b2b_restart_we", VW'(mem_write_enable), VW'(1));
    chk("b2b_restart_wd", VW'(mem_wdata), VW'(1));
    start = 1'b0;
    run_to_done(40, we_n, re_n, seen);
    chk("b2b_done2_seen", VW'(seen), VW'(1));
    chk("b2b_we_cnt2",    VW'(we_n), VW'(BL));
    tick();

    // start pulsed at beat 5 of a load is ignored
    is_store = 1'b0;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    re_n   = 0;
    done_n = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      if (mem_read_enable) re_n++;
      if (done) done_n++;
      tick();
    end
    chk("ign_re_cnt",  VW'(re_n), VW'(BL));
    chk("ign_done_cnt", VW'(done_n), VW'(1));

    // reset at beat 9 of a store
    is_store = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("rmid_pre_we", VW'(mem_write_enable), VW'(1));
    rst = 1'b1;
    #1;
    chk("rmid_we",   VW'(mem_write_enable), VW'(0));
    chk("rmid_busy", VW'(busy), VW'(0));
    chk("rmid_wd",   VW'(mem_wdata), VW'(0));
    chk("rmid_rvec", rdata_vec, VW'(0));
    tick();
    rst = 1'b0;
    chk("rmid_no_done", VW'(done), VW'(0));
    tick();
    chk("rmid_idle_busy", VW'(busy), VW'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(40, we_n, re_n, seen);
    chk("rmid_rerun_seen", VW'(seen), VW'(1));
    chk("rmid_rerun_we",   VW'(we_n), VW'(BL));
    tick();

`ifdef VEC_XFER_BOUNDS_CHECK_EN
    // overflowing base is rejected
    base_addr = 19'h7FFF0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("bnd_err",  VW'(err), VW'(1));
    chk("bnd_done", VW'(done), VW'(1));
    chk("bnd_we",   VW'(mem_write_enable), VW'(0));
    chk("bnd_busy", VW'(busy), VW'(0));
    tick();
    chk("bnd_err_once", VW'(err), VW'(0));
    chk("bnd_we_after", VW'(mem_write_enable), VW'(0));

    // last element exactly at 0x7FFFE is accepted
    base_addr = 19'h7FFED;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("bnd_ok_err",  VW'(err), VW'(0));
    chk("bnd_ok_we",   VW'(mem_write_enable), VW'(1));
    chk("bnd_ok_addr", VW'(mem_addr), VW'(19'h7FFED));
    run_to_done(40, we_n, re_n, seen);
    chk("bnd_ok_seen", VW'(seen), VW'(1));
    chk("bnd_ok_cnt",  VW'(we_n), VW'(BL));
    chk("bnd_ok_done_err", VW'(err), VW'(0));
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
